count_display_scan: RTL and testbench
=====================================

// Module: count_display_scan
// PURPOSE
//  Downstream display stage for the 4-bit synchronous counter: captures each new count value into a
//  NUM_DIGITS-deep history and time-multiplexes it onto a common-anode 7-segment display.
//  Digit 0 (rightmost) shows the newest count; higher digits show older counts.
//  A wrap of the counter from 4'hF to 4'h0 is flagged on the decimal point.
// PARAMETERS
//  REFRESH_DIV     1000  clock cycles each digit stays enabled (>=2)
//  NUM_DIGITS      4     number of digits / history depth (2..8)
//  SEG_ACTIVE_LOW  1     1: seg_o/dp_o active-low; 0: active-high
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rest         in   1           synchronous reset, active-high
//  cnt_i        in   4           counter value (q of the counter stage)
//  cnt_valid_i  in   1           cnt_i qualifies this cycle
//  freeze_i     in   1           1: ignore captures, hold history
//  seg_o        out  7           segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dp_o         out  1           decimal point, polarity per SEG_ACTIVE_LOW
//  an_o         out  NUM_DIGITS  digit enables, always active-low, one-hot-zero when scanning
// BEHAVIOUR
//  Reset (rest=1 at clk edge): history all 4'h0, last_q=4'h0, wrap flag 0, prescaler 0, scan index 0,
//   an_o all 1s, seg_o and dp_o at inactive level. Reset mid-scan/mid-capture discards all state.
//  Capture: cnt_valid_i=1 & freeze_i=0 & cnt_i!=last_q -> hist[k]<=hist[k-1] (k>=1), hist[0]<=cnt_i,
//   last_q<=cnt_i. Repeated equal values do not shift. History visible on outputs 1 cycle later.
//  Wrap flag: set on a capture with last_q==4'hF and cnt_i==4'h0; cleared on any other capture;
//   held while freeze_i=1.
//  Prescaler: counts 0..REFRESH_DIV-1, wraps to 0; scan index advances (mod NUM_DIGITS) on the
//   cycle prescaler==REFRESH_DIV-1. Scan order 0,1,..,NUM_DIGITS-1,0,...
//  Outputs registered: an_o[i]=0 iff i==scan index (first enable appears the cycle after reset
//   deasserts); seg_o=decode(hist[scan]); dp_o active iff scan==0 & wrap flag. Outputs change
//   only in the same cycle as the scan index, except a capture updates seg_o of the current digit.
//  Decode: standard hex 0-9,A,b,C,d,E,F; e.g. 4'h0 -> {g..a}=7'b0111111 active-high.
//  Simultaneous capture and scan advance: new digit shows post-capture history.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digits i>=1 whose value and all higher-digit values are 4'h0
//   drive seg_o/dp_o inactive (an_o still scans). Digit 0 never blanked.
//  Not defined: all digits always decoded, zeros shown.
// STRUCTURE
//  Package disp_pkg: typedef logic [3:0] nibble_t; typedef logic [6:0] seg_t; SEG_BLANK constant;
//   16-entry hex segment table (active-high).
//  Sub-module hex_to_seg7 (combinational nibble_t -> seg_t); polarity applied in this block.
// TESTING (REFRESH_DIV=4, NUM_DIGITS=4 for bench)
//  1 reset: hold rest 3 cycles -> an_o=4'b1111, seg_o=7'h7F (inactive); after release an_o=4'b1110,
//    then 4'b1101 after 4 more cycles, full cycle of 16 cycles.
//  2 capture: valid 1,2,3,3 -> history {0,1,2,3} (d3..d0); digit0 shows 3 = 7'b1001111 active-high;
//    the second 3 causes no shift.
//  3 wrap: capture E,F,0 -> dp_o active only while an_o=4'b1110; next capture 1 clears it.
//  4 freeze: freeze_i=1, valid 5,6 -> history and dp unchanged; release then 7 -> hist[0]=7.
//  5 reset mid-scan at scan index 2 with history {4,5,6,7} -> history 0, an_o all 1s next cycle.
//  6 LEADING_ZERO_BLANK_EN: history {0,0,3,0} -> digits 2,3 blank, digit1 '3', digit0 '0';
//    without macro all four decoded.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and the hex-to-7-segment lookup for the count display path.
// Exports: nibble_t (one hex digit), seg_t ({g,f,e,d,c,b,a}), SEG_BLANK and HEX_SEG_TABLE.
// Every segment pattern in this package is active-high. Output polarity is applied by the consumer.
package disp_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg_t;

  // All segments off (active-high view).
  localparam seg_t SEG_BLANK = 7'h00;

  // Standard hex glyphs 0-9, A, b, C, d, E, F in {g,f,e,d,c,b,a} order.
  localparam seg_t HEX_SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/count_display_scan_hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder. The output is active-high.
// Ports: nib_i (hex digit in), seg_o (segments {g,f,e,d,c,b,a}, active-high).
// This block has no clock and no state.
module hex_to_seg7
  import disp_pkg::*;
(
  input  nibble_t nib_i,
  output seg_t    seg_o
);

  assign seg_o = HEX_SEG_TABLE[nib_i];

endmodule

// File: rtl/count_display_scan.sv
// Count display stage. It keeps a NUM_DIGITS-deep history of changing counter values and
// scans that history onto a common-anode 7-segment display. Digit 0 shows the newest value.
// A wrap of the count from F to 0 lights the decimal point on digit 0.
// Ports: clk, rest (synchronous, active-high), cnt_i/cnt_valid_i (count in), freeze_i (hold the history),
//        seg_o/dp_o (segment outputs; polarity is set by SEG_ACTIVE_LOW), an_o (digit enables, active-low).
// Optional: define LEADING_ZERO_BLANK_EN to blank leading-zero digits above digit 0.
module count_display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 1000,
  parameter int NUM_DIGITS     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [3:0]            cnt_i,
  input  logic                  cnt_valid_i,
  input  logic                  freeze_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(NUM_DIGITS - 1);
  // Inactive output levels, which follow the segment polarity.
  localparam seg_t SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic DP_OFF  = SEG_ACTIVE_LOW;

  nibble_t                 hist_q [NUM_DIGITS];
  nibble_t                 hist_d [NUM_DIGITS];
  nibble_t                 last_q, last_d;
  logic                    wrap_q, wrap_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    capture;
  logic                    blank;
  nibble_t                 cur_nib;
  seg_t                    dec_seg;
  seg_t                    seg_act;
  logic                    dp_act;

  // Update the history and wrap flag. Repeated values and frozen cycles leave both unchanged.
  always_comb begin
    capture = cnt_valid_i && !freeze_i && (cnt_i != last_q);
    hist_d  = hist_q;
    last_d  = last_q;
    wrap_d  = wrap_q;
    if (capture) begin
      hist_d[0] = cnt_i;
      for (int k = 1; k < NUM_DIGITS; k++) begin
        hist_d[k] = hist_q[k-1];
      end
      last_d = cnt_i;
      wrap_d = (last_q == 4'hF) && (cnt_i == 4'h0);
    end
  end

  // Refresh prescaler and scan index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    scan_d  = scan_q;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      scan_d  = (scan_q == SCAN_MAX) ? '0 : scan_q + 1'b1;
    end
  end

  // Output values are built from next-state values. An output register then changes in the
  // same cycle as the scan index. A capture shows up on the digit being scanned right away.
  assign cur_nib = hist_d[scan_d];

  hex_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above 0 is blank when it and every digit above it hold zero.
  always_comb begin
    blank = (scan_d != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(scan_d) && hist_d[j] != 4'h0) begin
        blank = 1'b0;
      end
    end
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d         = '1;
    an_d[scan_d] = 1'b0;
    seg_act      = blank ? SEG_BLANK : dec_seg;
    dp_act       = !blank && (scan_d == '0) && wrap_d;
    seg_d        = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d         = SEG_ACTIVE_LOW ? ~dp_act : dp_act;
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        hist_q[k] <= '0;
      end
      last_q  <= '0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
      scan_q  <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      hist_q  <= hist_d;
      last_q  <= last_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;
  assign dp_o  = dp_q;

endmodule

// File: tb/tb_count_display_scan.sv
// Directed bench for count_display_scan. It uses REFRESH_DIV=4, NUM_DIGITS=4 and active-low segments.
// The checks cover reset, scan timing, capture/no-shift, wrap dp, freeze, reset mid-scan and leading zeros.
// Expected segment codes come from the bench's own hex table, inverted to active-low.
module tb_count_display_scan;

  logic       clk;
  logic       rest;
  logic [3:0] cnt_i;
  logic       cnt_valid_i;
  logic       freeze_i;
  logic [6:0] seg_o;
  logic       dp_o;
  logic [3:0] an_o;

  int n_tests = 0;
  int n_fail  = 0;

  count_display_scan #(
    .REFRESH_DIV    (4),
    .NUM_DIGITS     (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .cnt_i       (cnt_i),
    .cnt_valid_i (cnt_valid_i),
    .freeze_i    (freeze_i),
    .seg_o       (seg_o),
    .dp_o        (dp_o),
    .an_o        (an_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low glyphs for the digits used by this bench.
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19;
  localparam logic [6:0] S7 = 7'h78;
  localparam logic [6:0] SOFF = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] SLZ = SOFF;
`else
  localparam logic [6:0] SLZ = S0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [3:0] v);
    cnt_i       = v;
    cnt_valid_i = 1'b1;
    tick();
    cnt_valid_i = 1'b0;
  endtask

  task automatic wait_digit(input int i);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << i);
    n = 0;
    while (an_o !== tgt && n < 40) begin
      tick();
      n++;
    end
    if (an_o !== tgt) check("digit_timeout", 32'(an_o), 32'(tgt));
  endtask

  initial begin
    rest        = 1'b1;
    cnt_i       = 4'h0;
    cnt_valid_i = 1'b0;
    freeze_i    = 1'b0;

    // 1: reset and scan timing
    repeat (3) tick();
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'(SOFF));
    check("rst_dp", 32'(dp_o), 32'h1);
    rest = 1'b0;
    tick();
    check("first_an", 32'(an_o), 32'hE);
    check("first_seg", 32'(seg_o), 32'(S0));
    repeat (4) tick();
    check("scan_d1", 32'(an_o), 32'hD);
    repeat (8) tick();
    check("scan_d3", 32'(an_o), 32'h7);
    repeat (4) tick();
    check("scan_wrap", 32'(an_o), 32'hE);

    // 2: captures 1,2,3,3 -> {0,1,2,3}
    capture(4'h1);
    capture(4'h2);
    capture(4'h3);
    capture(4'h3);
    wait_digit(0); check("cap_d0", 32'(seg_o), 32'(S3));
    wait_digit(1); check("cap_d1", 32'(seg_o), 32'(S2));
    wait_digit(2); check("cap_d2", 32'(seg_o), 32'(S1));
    wait_digit(3); check("cap_d3", 32'(seg_o), 32'(SLZ));

    // 3: wrap E,F,0 -> {3,E,F,0}, dp on digit 0 only
    capture(4'hE);
    capture(4'hF);
    capture(4'h0);
    wait_digit(0);
    check("wrap_dp_d0", 32'(dp_o), 32'h0);
    check("wrap_seg_d0", 32'(seg_o), 32'(S0));
    wait_digit(1); check("wrap_dp_d1", 32'(dp_o), 32'h1);
    wait_digit(3); check("wrap_dp_d3", 32'(dp_o), 32'h1);
    capture(4'h1);
    wait_digit(0);
    check("wrap_clr_dp", 32'(dp_o), 32'h1);
    check("wrap_clr_seg", 32'(seg_o), 32'(S1));

    // 4: freeze -> {E,F,0,1} held; then 7 -> {F,0,1,7}
    freeze_i = 1'b1;
    capture(4'h5);
    capture(4'h6);
    wait_digit(0);
    check("frz_d0", 32'(seg_o), 32'(S1));
    check("frz_dp", 32'(dp_o), 32'h1);
    wait_digit(1); check("frz_d1", 32'(seg_o), 32'(S0));
    freeze_i = 1'b0;
    capture(4'h7);
    wait_digit(0); check("unfrz_d0", 32'(seg_o), 32'(S7));
    wait_digit(1); check("unfrz_d1", 32'(seg_o), 32'(S1));

    // 5: reset mid-scan with {4,5,6,7}
    capture(4'h4);
    capture(4'h5);
    capture(4'h6);
    capture(4'h7);
    wait_digit(3); check("pre_rst_d3", 32'(seg_o), 32'(S4));
    wait_digit(2);
    rest = 1'b1;
    tick();
    check("mid_rst_an", 32'(an_o), 32'hF);
    check("mid_rst_seg", 32'(seg_o), 32'(SOFF));
    rest = 1'b0;
    tick();
    check("post_rst_an", 32'(an_o), 32'hE);
    check("post_rst_d0", 32'(seg_o), 32'(S0));
    wait_digit(3); check("post_rst_d3", 32'(seg_o), 32'(SLZ));

    // 6: leading zeros {0,0,3,0}
    capture(4'h3);
    capture(4'h0);
    wait_digit(0);
    check("lz_d0", 32'(seg_o), 32'(S0));
    check("lz_dp", 32'(dp_o), 32'h1);
    wait_digit(1); check("lz_d1", 32'(seg_o), 32'(S3));
    wait_digit(2); check("lz_d2", 32'(seg_o), 32'(SLZ));
    wait_digit(3); check("lz_d3", 32'(seg_o), 32'(SLZ));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
